// File: rtl/chr_bg_tilemap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : chr_bg_tilemap_pkg
//  Description : Shared constants and size helpers for the tile-map renderer.
//  Revision    : 1.0 - initial release
// ============================================================================
package chr_bg_tilemap_pkg;

    localparam int LATENCY = 9;

    localparam int DEF_MAP_SIZE_BITS  = 6;
    localparam int DEF_TILE_SIZE_BITS = 3;
    localparam int DEF_CHR_BITS       = 8;
    localparam int DEF_TEXEL_BITS     = 2;
    localparam int DEF_PAL_SEL_BITS   = 2;

    function automatic int map_addr_bits(input int map_size_bits);
        return 2 * map_size_bits;
    endfunction

    function automatic int tile_addr_bits(input int chr_bits, input int tile_size_bits);
        return chr_bits + 2 * tile_size_bits;
    endfunction

    function automatic int map_word_bits(input int chr_bits, input int pal_sel_bits);
        return chr_bits + pal_sel_bits + 2;
    endfunction

    function automatic int pal_addr_bits(input int pal_sel_bits, input int texel_bits);
        return pal_sel_bits + texel_bits;
    endfunction

    // Map entry layout, LSB first: name, pal_sel, hflip, vflip
    function automatic int entry_name_lsb();
        return 0;
    endfunction

    function automatic int entry_pal_lsb(input int chr_bits);
        return chr_bits;
    endfunction

    function automatic int entry_hflip_bit(input int chr_bits, input int pal_sel_bits);
        return chr_bits + pal_sel_bits;
    endfunction

    function automatic int entry_vflip_bit(input int chr_bits, input int pal_sel_bits);
        return chr_bits + pal_sel_bits + 1;
    endfunction

    localparam int MAP_ADDR_BITS  = map_addr_bits(DEF_MAP_SIZE_BITS);
    localparam int TILE_ADDR_BITS = tile_addr_bits(DEF_CHR_BITS, DEF_TILE_SIZE_BITS);
    localparam int MAP_WORD_BITS  = map_word_bits(DEF_CHR_BITS, DEF_PAL_SEL_BITS);
    localparam int PAL_ADDR_BITS  = pal_addr_bits(DEF_PAL_SEL_BITS, DEF_TEXEL_BITS);
    localparam int ENTRY_NAME_LSB = entry_name_lsb();
    localparam int ENTRY_PAL_LSB  = entry_pal_lsb(DEF_CHR_BITS);
    localparam int ENTRY_HFLIP    = entry_hflip_bit(DEF_CHR_BITS, DEF_PAL_SEL_BITS);
    localparam int ENTRY_VFLIP    = entry_vflip_bit(DEF_CHR_BITS, DEF_PAL_SEL_BITS);

endpackage
`default_nettype wire

// File: rtl/chr_bg_palette.sv
`default_nettype none
// ============================================================================
//  Module      : chr_bg_palette
//  Description : Palette register file, cleared on reset, registered read that
//                returns 0 when the read is not enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module chr_bg_palette #(
    parameter int ADDR_BITS  = 4,
    parameter int COLOR_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_we,
    input  logic [ADDR_BITS-1:0]  i_waddr,
    input  logic [COLOR_BITS-1:0] i_din,
    input  logic                  i_ren,
    input  logic [ADDR_BITS-1:0]  i_raddr,
    output logic [COLOR_BITS-1:0] o_rdata
);

    localparam int DEPTH = 2**ADDR_BITS;

    logic [COLOR_BITS-1:0] r_mem [DEPTH];
    logic [COLOR_BITS-1:0] r_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_waddr] <= i_din;
            end
            r_rdata <= i_ren ? r_mem[i_raddr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/chr_bg_tilemap_bram.sv
`default_nettype none
// ============================================================================
//  Module      : chr_bg_tilemap_bram
//  Description : Single-clock block RAM, one write port, read-first read port
//                with read register plus output register (2-cycle read).
//  Revision    : 1.0 - initial release
// ============================================================================
module chr_bg_tilemap_bram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_waddr,
    input  logic [DATA_BITS-1:0] i_din,
    input  logic [ADDR_BITS-1:0] i_raddr,
    output logic [DATA_BITS-1:0] o_dout
);

    logic [DATA_BITS-1:0] r_mem [2**ADDR_BITS];
    logic [DATA_BITS-1:0] r_rd;
    logic [DATA_BITS-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_din;
        end
        r_rd <= r_mem[i_raddr];
        r_q  <= r_rd;
    end

    assign o_dout = r_q;

endmodule
`default_nettype wire

// File: rtl/chr_bg_tilemap.sv
`default_nettype none
// ============================================================================
//  Module      : chr_bg_tilemap
//  Description : Scrollable, scalable tile-map background renderer, 9-cycle
//                fixed-latency pipeline. Optional transparent output enabled
//                by define CHR_BG_TILEMAP_TRANSPARENT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module chr_bg_tilemap
    import chr_bg_tilemap_pkg::*;
#(
    parameter int MAP_SIZE_BITS   = 6,
    parameter int TILE_SIZE_BITS  = 3,
    parameter int CHR_BITS        = 8,
    parameter int TEXEL_BITS      = 2,
    parameter int PAL_SEL_BITS    = 2,
    parameter int COLOR_BITS      = 8,
    parameter int OFFSET_BITS     = 16,
    parameter int SCALE_BITS_BITS = 4,
    parameter int SCALE_DIV_BITS  = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               map_we,
    input  logic [31:0]                        map_address,
    input  logic [CHR_BITS+PAL_SEL_BITS+1:0]   map_din,
    input  logic                               tile_we,
    input  logic [31:0]                        tile_address,
    input  logic [TEXEL_BITS-1:0]              tile_din,
    input  logic                               pal_we,
    input  logic [31:0]                        pal_address,
    input  logic [COLOR_BITS-1:0]              pal_din,
    output logic [31:0]                        map_length,
    output logic [31:0]                        tile_length,
    input  logic [31:0]                        x,
    input  logic [31:0]                        y,
    input  logic [31:0]                        scale,
    input  logic                               frame_start,
    input  logic                               pix_valid,
    input  logic [31:0]                        count_h,
    input  logic [31:0]                        count_v,
    output logic                               color_valid,
    output logic [COLOR_BITS-1:0]              color
`ifdef CHR_BG_TILEMAP_TRANSPARENT_EN
    ,
    output logic                               transparent
`endif
);

    localparam int c_map_aw  = map_addr_bits(MAP_SIZE_BITS);
    localparam int c_tile_aw = tile_addr_bits(CHR_BITS, TILE_SIZE_BITS);
    localparam int c_word_w  = map_word_bits(CHR_BITS, PAL_SEL_BITS);
    localparam int c_pal_aw  = pal_addr_bits(PAL_SEL_BITS, TEXEL_BITS);
    localparam int c_name_lo = entry_name_lsb();
    localparam int c_pal_lo  = entry_pal_lsb(CHR_BITS);
    localparam int c_hflip   = entry_hflip_bit(CHR_BITS, PAL_SEL_BITS);
    localparam int c_vflip   = entry_vflip_bit(CHR_BITS, PAL_SEL_BITS);
    localparam int c_dx_w    = OFFSET_BITS + 2**SCALE_BITS_BITS;
    localparam int c_crd_w   = MAP_SIZE_BITS + TILE_SIZE_BITS;

    logic [OFFSET_BITS-1:0]     r_x_act, r_y_act;
    logic [SCALE_BITS_BITS-1:0] r_scale_act, r_scale_d1;
    logic [OFFSET_BITS-1:0]     r_dx0, r_dy0;
    logic [c_dx_w-1:0]          w_dx_sh, w_dy_sh, w_dx1, w_dy1;
    logic [c_crd_w-1:0]         r_dx1, r_dy1;
    logic [c_map_aw-1:0]        r_map_addr;
    logic [TILE_SIZE_BITS-1:0]  r_tx_d3, r_tx_d4, r_tx_d5;
    logic [TILE_SIZE_BITS-1:0]  r_ty_d3, r_ty_d4, r_ty_d5;
    logic [c_word_w-1:0]        w_entry;
    logic [c_tile_aw-1:0]       r_tile_addr;
    logic [PAL_SEL_BITS-1:0]    r_pal_d6, r_pal_d7, r_pal_d8;
    logic [TEXEL_BITS-1:0]      w_texel;
    logic [LATENCY-1:0]         r_vpipe;
    logic                       w_pal_ren;
    logic [c_pal_aw-1:0]        w_pal_raddr;
    logic                       w_unused;

    assign map_length  = 32'd1 << c_map_aw;
    assign tile_length = 32'd1 << c_tile_aw;

    // Widen before shifting so magnification never loses the high bits
    assign w_dx_sh = {{(c_dx_w-OFFSET_BITS){1'b0}}, r_dx0} << r_scale_d1;
    assign w_dy_sh = {{(c_dx_w-OFFSET_BITS){1'b0}}, r_dy0} << r_scale_d1;
    assign w_dx1   = w_dx_sh >> SCALE_DIV_BITS;
    assign w_dy1   = w_dy_sh >> SCALE_DIV_BITS;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x_act     <= '0;
            r_y_act     <= '0;
            r_scale_act <= '0;
            r_scale_d1  <= '0;
            r_dx0       <= '0;
            r_dy0       <= '0;
            r_dx1       <= '0;
            r_dy1       <= '0;
            r_map_addr  <= '0;
            r_tx_d3     <= '0;
            r_tx_d4     <= '0;
            r_tx_d5     <= '0;
            r_ty_d3     <= '0;
            r_ty_d4     <= '0;
            r_ty_d5     <= '0;
            r_tile_addr <= '0;
            r_pal_d6    <= '0;
            r_pal_d7    <= '0;
            r_pal_d8    <= '0;
            r_vpipe     <= '0;
        end else begin
            if (frame_start) begin
                r_x_act     <= x[OFFSET_BITS-1:0];
                r_y_act     <= y[OFFSET_BITS-1:0];
                r_scale_act <= scale[SCALE_BITS_BITS-1:0];
            end
            // A pixel sampled with frame_start still sees the previous frame's values
            r_dx0       <= count_h[OFFSET_BITS-1:0] - r_x_act;
            r_dy0       <= count_v[OFFSET_BITS-1:0] - r_y_act;
            r_scale_d1  <= r_scale_act;
            r_dx1       <= w_dx1[c_crd_w-1:0];
            r_dy1       <= w_dy1[c_crd_w-1:0];
            r_map_addr  <= {r_dy1[c_crd_w-1:TILE_SIZE_BITS], r_dx1[c_crd_w-1:TILE_SIZE_BITS]};
            r_tx_d3     <= r_dx1[TILE_SIZE_BITS-1:0];
            r_ty_d3     <= r_dy1[TILE_SIZE_BITS-1:0];
            r_tx_d4     <= r_tx_d3;
            r_ty_d4     <= r_ty_d3;
            r_tx_d5     <= r_tx_d4;
            r_ty_d5     <= r_ty_d4;
            r_tile_addr <= {w_entry[c_name_lo +: CHR_BITS],
                            r_ty_d5 ^ {TILE_SIZE_BITS{w_entry[c_vflip]}},
                            r_tx_d5 ^ {TILE_SIZE_BITS{w_entry[c_hflip]}}};
            r_pal_d6    <= w_entry[c_pal_lo +: PAL_SEL_BITS];
            r_pal_d7    <= r_pal_d6;
            r_pal_d8    <= r_pal_d7;
            r_vpipe     <= {r_vpipe[LATENCY-2:0], pix_valid};
        end
    end

    chr_bg_tilemap_bram #(
        .ADDR_BITS (c_map_aw),
        .DATA_BITS (c_word_w)
    ) u_map_ram (
        .clk     (clk),
        .i_we    (map_we),
        .i_waddr (map_address[c_map_aw-1:0]),
        .i_din   (map_din),
        .i_raddr (r_map_addr),
        .o_dout  (w_entry)
    );

    chr_bg_tilemap_bram #(
        .ADDR_BITS (c_tile_aw),
        .DATA_BITS (TEXEL_BITS)
    ) u_tile_ram (
        .clk     (clk),
        .i_we    (tile_we),
        .i_waddr (tile_address[c_tile_aw-1:0]),
        .i_din   (tile_din),
        .i_raddr (r_tile_addr),
        .o_dout  (w_texel)
    );

    assign w_pal_raddr = {r_pal_d8, w_texel};

`ifdef CHR_BG_TILEMAP_TRANSPARENT_EN
    logic r_transparent;

    assign w_pal_ren = r_vpipe[LATENCY-2] && (w_texel != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_transparent <= 1'b0;
        end else begin
            r_transparent <= r_vpipe[LATENCY-2] && (w_texel == '0);
        end
    end

    assign transparent = r_transparent;
`else
    assign w_pal_ren = r_vpipe[LATENCY-2];
`endif

    chr_bg_palette #(
        .ADDR_BITS  (c_pal_aw),
        .COLOR_BITS (COLOR_BITS)
    ) u_palette (
        .clk     (clk),
        .reset   (reset),
        .i_we    (pal_we),
        .i_waddr (pal_address[c_pal_aw-1:0]),
        .i_din   (pal_din),
        .i_ren   (w_pal_ren),
        .i_raddr (w_pal_raddr),
        .o_rdata (color)
    );

    assign color_valid = r_vpipe[LATENCY-1];

    assign w_unused = &{1'b0, map_address[31:c_map_aw], tile_address[31:c_tile_aw],
                        pal_address[31:c_pal_aw], x[31:OFFSET_BITS], y[31:OFFSET_BITS],
                        scale[31:SCALE_BITS_BITS], count_h[31:OFFSET_BITS],
                        count_v[31:OFFSET_BITS], w_dx1[c_dx_w-1:c_crd_w],
                        w_dy1[c_dx_w-1:c_crd_w]};

endmodule
`default_nettype wire

// File: doc/chr_bg_tilemap.md
Name: chr_bg_tilemap

Overview:
Single-clock, parametrised successor to the character background renderer. It draws a scrollable, scalable tile-map background. Tiles are CHR-selected, multi-bit-per-texel, and can be flipped per tile; each map entry picks its own palette. Scroll and scale are double-buffered and latched at frame start. A valid-qualified, fixed-latency pipeline feeds the video mixer, which sits in the same clock domain as the pixel counters.

Parameters:
MAP_SIZE_BITS, 6, map is 2^n x 2^n tiles; map address width 2*n
TILE_SIZE_BITS, 3, tile is 2^n x 2^n texels
CHR_BITS, 8, tile-name width in map entry
TEXEL_BITS, 2, bits per texel
PAL_SEL_BITS, 2, palette-select width in map entry
COLOR_BITS, 8, output colour width
OFFSET_BITS, 16, scroll/counter width used
SCALE_BITS_BITS, 4, scale shift field width
SCALE_DIV_BITS, 8, fixed right shift after scale (scale=8 is 1:1)

Ports:
clk  in  1  pixel/system clock
reset  in  1  asynchronous, active-low reset
map_we/map_address/map_din  in  1/32/MAP_WORD_BITS  map RAM write port; entry = {vflip,hflip,pal_sel,name}; MAP_WORD_BITS = CHR_BITS+PAL_SEL_BITS+2
tile_we/tile_address/tile_din  in  1/32/TEXEL_BITS  tile RAM write; addr = {name,ty,tx}
pal_we/pal_address/pal_din  in  1/32/COLOR_BITS  palette write; addr = {pal_sel,texel}
map_length, tile_length  out  32  constants 2^(2*MAP_SIZE_BITS), 2^(CHR_BITS+2*TILE_SIZE_BITS)
x, y  in  32  scroll offsets (low OFFSET_BITS used), shadow
scale  in  32  low SCALE_BITS_BITS used, shadow
frame_start  in  1  one-cycle pulse; copies x,y,scale into active registers
pix_valid  in  1  pixel request qualifier
count_h, count_v  in  32  pixel coordinates (low OFFSET_BITS used)
color_valid  out  1  pix_valid delayed 9 cycles
color  out  COLOR_BITS  pixel colour

Behaviour:
- Reset (async assert, sync release): active x/y/scale=0, color=0, color_valid=0, valid pipe cleared, palette registers 0. Map/tile RAM contents are not reset.
- Shadow update: on a clk edge with frame_start=1, the active registers take x,y,scale. A pixel sampled on that same edge uses the old values.
- Stage d1: dx0=count_h-x_act, dy0=count_v-y_act, modulo 2^OFFSET_BITS.
- Stage d2: dx1=(dx0<<scale_act)>>SCALE_DIV_BITS, in OFFSET_BITS+2^SCALE_BITS_BITS bits. Same for dy1.
- Stage d3: map address={dy1[MAP+TILE-1:TILE], dx1[MAP+TILE-1:TILE]}. Upper bits are dropped, so the map wraps toroidally. Texel tx/ty = low TILE_SIZE_BITS bits, pipelined to d5.
- d5: map entry from RAM (registered address + registered output, 2 cycles).
- d6: tile address={name, ty^{vflip}, tx^{hflip}}. pal_sel and valid are delayed to d8.
- d8: texel from tile RAM.
- d9: color <= palette[{pal_sel,texel}] when valid_d8, else 0; color_valid <= valid_d8.
- Latency is exactly 9 cycles, fully pipelined, one pixel per cycle, no stalls. Gaps in pix_valid propagate unchanged.
- RAMs are read-first: a write to the address being read the same cycle returns old data. A palette write is visible to d9 on the next cycle.
- Writes whose address exceeds the length are truncated to the address width (wrap).
- reset asserted mid-frame: color_valid and color go to 0 immediately; in-flight pixels are discarded.

Optional Feature:
CHR_BG_TILEMAP_TRANSPARENT_EN:
- Defined: adds output port transparent (1 bit, reset 0). It is 1 with color_valid when texel==0, and color is then forced to 0.
- Undefined: no port, and texel 0 indexes the palette like any other value.

Decomposition:
- Package chr_bg_tilemap_pkg holds derived constants: MAP_ADDR_BITS, TILE_ADDR_BITS, MAP_WORD_BITS, PAL_ADDR_BITS, LATENCY=9, and the map-entry field offsets (name, pal_sel, hflip, vflip).
- Sub-module chr_bg_palette: a 2^PAL_ADDR_BITS x COLOR_BITS register file with one write port, an async-reset clear, and a registered read.
- The RAMs use the existing single-clock block RAM primitive.

Test Plan:
- Basic pixel: scale=8, x=y=0, frame_start; map[0]=name 1/pal 0; tile(1,0,0)=2; pal[2]=0x55; pix_valid at (0,0) -> color=0x55 with color_valid exactly 9 cycles later.
- H/V flip: map[0] hflip=1, tile(1,7,0)=3, pal[3]=0xAA, pixel (0,0) -> 0xAA. Then vflip only, tile(1,0,7)=1, pal[1]=0x11 -> 0x11.
- Wrap and palette select: x=1, map[63]=name 2/pal 3, tile(2,7,0)=1, pal[13]=0x3C, pixel (0,0) -> 0x3C.
- Scale: scale=7 (2x magnify) -> pixels h=0..15 all come from map column 0. Scale=9 -> pixel h=4 comes from map column 1.
- Shadow timing: change x to 8 without frame_start -> output unchanged. Pulse frame_start together with a pixel -> that pixel uses the old x, and the next pixel uses the new x.
- Reset mid-stream: 20 back-to-back valid pixels, assert reset at pixel 5 -> color_valid=0 and color=0 in the same cycle. After release, no stale valid pulses appear.
